keypad_sm_entry: RTL and testbench

- Input-side counterpart to the multiplexed seven-segment display driver: scans a 4x4 matrix keypad (Pmod KYPD layout) one column at a time, debounces the result and turns key presses into a sign-magnitude operand for the sign-magnitude adder.
- The display driver shows the in-progress entry (edit_mag/edit_sign).
- The adder consumes the committed operand (mag/sign) when valid pulses.

---
 rtl/keypad_sm_entry.sv | 251 +++++++++++++++++++++++++
 tb/tb_keypad_sm_entry.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_sm_entry.sv
// Keypad scanner and sign-magnitude operand entry.
// Drives one column of a 4x4 matrix keypad low at a time, samples the rows at
// the end of each column period, resolves a whole sweep into "one key" or
// "none", debounces over several sweeps and turns each clean press into an
// edit action on the operand being typed.
module keypad_sm_entry #(
    parameter int SCAN_TICKS      = 100000,
    parameter int DEBOUNCE_SWEEPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic [7:0] edit_mag,
    output logic       edit_sign,
    output logic [7:0] mag,
    output logic       sign,
    output logic       valid
);

    localparam int            TW         = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int            MW         = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_TICKS - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_SWEEPS);
    // Sweep result encoding: bit 4 = a key is present, bits 3:0 = its code.
    localparam logic [4:0]    KEY_NONE   = 5'b0_0000;

    // Hex code of the key at row r, column c.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    logic [TW-1:0]      tick_r;
    logic [1:0]         col_idx_r;
    logic [3:0]         col_r;
    // Row samples of columns 0..2; column 3 is taken straight from row on the
    // edge where the sweep is resolved.
    logic [2:0][3:0]    samp_r;
    logic [4:0]         prev_r;
    logic [MW-1:0]      match_r;
    logic [4:0]         stable_r;
    logic [3:0]         key_code_r;
    logic               key_strobe_r;
    logic [7:0]         edit_mag_r;
    logic               edit_sign_r;
    logic [7:0]         mag_r;
    logic               sign_r;
    logic               valid_r;

    logic               tick_last_s;
    logic               sweep_done_s;
    logic [15:0]        sweep_bits_s;
    logic [4:0]         low_cnt_s;
    logic [3:0]         hit_code_s;
    logic [4:0]         result_s;
    logic [MW-1:0]      match_next_s;
    logic [4:0]         stable_next_s;
    logic               press_s;
    logic [3:0]         press_code_s;
    logic [11:0]        cand_s;
    logic [7:0]         edit_mag_next_s;
    logic               edit_sign_next_s;
    logic               commit_s;

    assign tick_last_s  = (tick_r == TICK_LAST);
    assign sweep_done_s = tick_last_s && (col_idx_r == 2'd3);
    // Bit index is {col, row}.
    assign sweep_bits_s = {row, samp_r[2], samp_r[1], samp_r[0]};
    assign press_code_s = stable_next_s[3:0];
    assign cand_s       = ({4'd0, edit_mag_r} * 12'd10) + {8'd0, press_code_s};

    // Count low row bits across the sweep and remember where the last one was.
    always_comb begin
        low_cnt_s  = 5'd0;
        hit_code_s = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (!sweep_bits_s[i]) begin
                low_cnt_s  = low_cnt_s + 5'd1;
                hit_code_s = key_map(2'(i % 4), 2'(i / 4));
            end else begin
                low_cnt_s  = low_cnt_s;
            end
        end
    end

    // Exactly one closed contact is a key; none or ghosting/multi-press is "none".
    always_comb begin
        if (low_cnt_s == 5'd1) begin
            result_s = {1'b1, hit_code_s};
        end else begin
            result_s = KEY_NONE;
        end
    end

    // Debounce: count consecutive identical sweeps, accept at the threshold.
    always_comb begin
        if (result_s == prev_r) begin
            if (match_r == MATCH_MAX) begin
                match_next_s = match_r;
            end else begin
                match_next_s = match_r + MW'(1);
            end
        end else begin
            match_next_s = MW'(1);
        end
        if (match_next_s == MATCH_MAX) begin
            stable_next_s = result_s;
        end else begin
            stable_next_s = stable_r;
        end
        // Only none -> key counts; key -> other key needs a release first.
        press_s = sweep_done_s && !stable_r[4] && stable_next_s[4];
    end

    // Apply the pressed key to the operand being edited.
    always_comb begin
        edit_mag_next_s  = edit_mag_r;
        edit_sign_next_s = edit_sign_r;
        commit_s         = 1'b0;
        if (press_s) begin
            case (press_code_s)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                    // A digit that would overflow 8 bits is dropped.
                    if (cand_s <= 12'd255) begin
                        edit_mag_next_s = cand_s[7:0];
                    end else begin
                        edit_mag_next_s = edit_mag_r;
                    end
                end
                4'hA: edit_sign_next_s = ~edit_sign_r;
                4'hC: begin
                    edit_mag_next_s  = 8'd0;
                    edit_sign_next_s = 1'b0;
                end
                4'hE: begin
                    commit_s         = 1'b1;
                    edit_mag_next_s  = 8'd0;
                    edit_sign_next_s = 1'b0;
                end
                default: begin
                    edit_mag_next_s  = edit_mag_r;
                    edit_sign_next_s = edit_sign_r;
                end
            endcase
        end else begin
            edit_mag_next_s  = edit_mag_r;
            edit_sign_next_s = edit_sign_r;
        end
    end

    // Column scan timer, column drive and per-column row sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_r    <= '0;
            col_idx_r <= 2'd0;
            col_r     <= 4'b1110;
            samp_r    <= '0;
        end else if (tick_last_s) begin
            tick_r    <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            col_r     <= {col_r[2:0], col_r[3]};
            case (col_idx_r)
                2'd0:    samp_r[0] <= row;
                2'd1:    samp_r[1] <= row;
                2'd2:    samp_r[2] <= row;
                default: samp_r    <= samp_r;
            endcase
        end else begin
            tick_r <= tick_r + TW'(1);
        end
    end

    // Debounce state, updated once per completed sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r   <= KEY_NONE;
            match_r  <= '0;
            stable_r <= KEY_NONE;
        end else if (sweep_done_s) begin
            prev_r   <= result_s;
            match_r  <= match_next_s;
            stable_r <= stable_next_s;
        end else begin
            prev_r   <= prev_r;
        end
    end

    // Key event outputs, edit registers and committed operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code_r   <= 4'h0;
            key_strobe_r <= 1'b0;
            edit_mag_r   <= 8'd0;
            edit_sign_r  <= 1'b0;
            mag_r        <= 8'd0;
            sign_r       <= 1'b0;
            valid_r      <= 1'b0;
        end else begin
            key_strobe_r <= press_s;
            valid_r      <= commit_s;
            edit_mag_r   <= edit_mag_next_s;
            edit_sign_r  <= edit_sign_next_s;
            if (press_s) begin
                key_code_r <= press_code_s;
            end else begin
                key_code_r <= key_code_r;
            end
            if (commit_s) begin
                mag_r  <= edit_mag_r;
                // Negative zero is folded to positive zero.
                sign_r <= edit_sign_r && (edit_mag_r != 8'd0);
            end else begin
                mag_r  <= mag_r;
                sign_r <= sign_r;
            end
        end
    end

    assign col        = col_r;
    assign key_code   = key_code_r;
    assign key_strobe = key_strobe_r;
    assign edit_mag   = edit_mag_r;
    assign edit_sign  = edit_sign_r;
    assign mag        = mag_r;
    assign sign       = sign_r;
    assign valid      = valid_r;

endmodule

// File: tb/tb_keypad_sm_entry.sv
// Self-checking bench for keypad_sm_entry: a keypad model drives the rows from
// the column drive, a reference model pushes the expected result of every
// press onto a scoreboard, and a monitor pops and compares on each key_strobe.
module tb_keypad_sm_entry;

    localparam int SCAN_TICKS      = 4;
    localparam int DEBOUNCE_SWEEPS = 2;
    localparam int SWEEP           = 4 * SCAN_TICKS;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_strobe;
    logic [7:0] edit_mag;
    logic       edit_sign;
    logic [7:0] mag;
    logic       sign;
    logic       valid;

    keypad_sm_entry #(
        .SCAN_TICKS      (SCAN_TICKS),
        .DEBOUNCE_SWEEPS (DEBOUNCE_SWEEPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .edit_mag   (edit_mag),
        .edit_sign  (edit_sign),
        .mag        (mag),
        .sign       (sign),
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] code;
        logic [7:0] emag;
        logic       esign;
        logic       vld;
        logic [7:0] cmag;
        logic       csign;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;

    // Keypad layout, index r*4+c.
    int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    logic [15:0] pressed;
    int n_checks, n_pass, strobe_cnt, exp_strobes;
    int m_edit, m_cmag;
    logic m_esign, m_csign;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Keypad: a pressed switch pulls its row low while its column is driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] key_mask(input int code);
        logic [15:0] m;
        m = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (keymap[i] == code) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_reset();
        m_edit = 0; m_esign = 1'b0; m_cmag = 0; m_csign = 1'b0;
    endtask

    // Reference behaviour of one accepted key; pushes the expected outputs.
    task automatic expect_key(input int code);
        exp_t e;
        int   cand;
        logic vld;
        vld = 1'b0;
        if (code <= 9) begin
            cand = m_edit * 10 + code;
            if (cand <= 255) m_edit = cand;
        end else if (code == 10) begin
            m_esign = ~m_esign;
        end else if (code == 12) begin
            m_edit = 0; m_esign = 1'b0;
        end else if (code == 14) begin
            m_cmag  = m_edit;
            m_csign = m_esign && (m_edit != 0);
            m_edit  = 0; m_esign = 1'b0;
            vld     = 1'b1;
        end
        e.code  = 4'(code);
        e.emag  = 8'(m_edit);
        e.esign = m_esign;
        e.vld   = vld;
        e.cmag  = 8'(m_cmag);
        e.csign = m_csign;
        sb.push_back(e);
        exp_strobes++;
    endtask

    task automatic press(input int code);
        expect_key(code);
        pressed = key_mask(code);
        repeat (4 * SWEEP) @(negedge clk);
        pressed = 16'd0;
        repeat (4 * SWEEP) @(negedge clk);
        chk("drained", sb.size(), 0);
    endtask

    task automatic check_reset_state();
        chk("rst_col", col, 4'b1110);
        chk("rst_key_code", key_code, 0);
        chk("rst_key_strobe", key_strobe, 0);
        chk("rst_edit_mag", edit_mag, 0);
        chk("rst_edit_sign", edit_sign, 0);
        chk("rst_mag", mag, 0);
        chk("rst_sign", sign, 0);
        chk("rst_valid", valid, 0);
    endtask

    // Monitor: every strobe consumes one scoreboard entry.
    always @(negedge clk) begin
        if (key_strobe) begin
            strobe_cnt++;
            chk("strobe_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                got_e = sb.pop_front();
                chk("key_code", key_code, got_e.code);
                chk("edit_mag", edit_mag, got_e.emag);
                chk("edit_sign", edit_sign, got_e.esign);
                chk("valid", valid, got_e.vld);
                chk("mag", mag, got_e.cmag);
                chk("sign", sign, got_e.csign);
            end
        end
        if (valid) chk("valid_with_strobe", key_strobe, 1);
    end

    initial begin
        logic [3:0] exp_col;
        n_checks = 0; n_pass = 0; strobe_cnt = 0; exp_strobes = 0;
        model_reset();
        reset   = 1'b1;
        pressed = key_mask(5);
        repeat (3) @(negedge clk);
        check_reset_state();

        // Key 5 held from reset release for five sweeps; column walk.
        expect_key(5);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            chk("col_walk", col, exp_col);
        end
        repeat (5 * SWEEP - 20) @(negedge clk);
        pressed = 16'd0;
        repeat (4 * SWEEP) @(negedge clk);
        chk("hold_one_strobe", strobe_cnt, 1);
        chk("hold_edit_mag", edit_mag, 5);
        chk("drained", sb.size(), 0);

        // Digit entry and commit.
        press(12);
        press(1); press(2); press(8); press(14);
        chk("commit_mag", mag, 128);

        // Overflow digit is ignored but still strobes.
        press(2); press(5); press(5); press(6);
        chk("overflow_edit", edit_mag, 255);
        press(12);

        // Negative commit, then negative zero.
        press(10); press(4); press(2); press(14);
        press(10); press(14);

        // Bouncing key 7: no strobe while toggling each sweep.
        for (int t = 0; t < 4; t++) begin
            pressed = (t % 2 == 0) ? key_mask(7) : 16'd0;
            repeat (SWEEP) @(negedge clk);
        end
        chk("bounce_quiet", strobe_cnt, exp_strobes);
        press(7);

        // Two keys in one column: ghost/multi-press rejected.
        pressed = key_mask(3) | key_mask(9);
        repeat (4 * SWEEP) @(negedge clk);
        pressed = 16'd0;
        repeat (4 * SWEEP) @(negedge clk);
        chk("multi_quiet", strobe_cnt, exp_strobes);

        press(4); press(14); press(3);
        chk("pre_reset_mag", mag, 74);

        // Reset while key 9 is mid-debounce.
        pressed = key_mask(9);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_state();
        model_reset();
        repeat (2) @(negedge clk);
        expect_key(9);
        reset = 1'b0;
        repeat (4 * SWEEP) @(negedge clk);
        pressed = 16'd0;
        repeat (4 * SWEEP) @(negedge clk);
        chk("drained", sb.size(), 0);
        chk("strobe_count", strobe_cnt, exp_strobes);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
